// File: rtl/tea_pkg.sv
// Shared TEA definitions: key-schedule constant, initial decipher sum,
// block/key types and the iterative core's state encoding.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef logic [63:0]  block_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // The decipher schedule starts where the encipher schedule ends: delta*rounds mod 2^32.
  function automatic logic [31:0] TEA_SUM_INIT(input int unsigned rounds,
                                               input logic [31:0] delta = TEA_DELTA);
    return delta * 32'(rounds);
  endfunction

endpackage

// File: rtl/tea_decrypt_iter_if.sv
// Valid/ready bus for the TEA decipher: ciphertext+key in, plaintext out.
interface tea_decrypt_iter_if;
  import tea_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t data_in;
  key_t   key;
  logic   out_valid;
  logic   out_ready;
  block_t data_out;

  modport master (
    output in_valid, data_in, key, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, key, out_ready,
    output in_ready, out_valid, data_out
  );

endinterface

// File: rtl/tea_dec_round.sv
// One combinational TEA decipher round: v1 is unwound first, then v0 using the new v1.
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0] v0_in,
  input  logic [31:0] v1_in,
  input  logic [31:0] sum_in,
  input  key_t        key_in,
  output logic [31:0] v0_out,
  output logic [31:0] v1_out
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] v1_n;

  assign k0 = key_in[127:96];
  assign k1 = key_in[95:64];
  assign k2 = key_in[63:32];
  assign k3 = key_in[31:0];

  assign v1_n   = v1_in - (((v0_in << 4) + k2) ^ (v0_in + sum_in) ^ ((v0_in >> 5) + k3));
  assign v0_out = v0_in - (((v1_n << 4) + k0) ^ (v1_n + sum_in) ^ ((v1_n >> 5) + k1));
  assign v1_out = v1_n;

endmodule

// File: rtl/tea_decrypt_iter.sv
// Iterative TEA block decipher, one round per clock (two per clock when
// TEA_DEC_UNROLL2_EN is defined; ROUNDS must then be even).
module tea_decrypt_iter
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input logic           clk,
  input logic           reset,
  tea_decrypt_iter_if.slave bus
);

`ifdef TEA_DEC_UNROLL2_EN
  localparam int unsigned STEPS    = ROUNDS / 2;
  localparam logic [31:0] SUM_STEP = DELTA << 1;
  if ((ROUNDS % 2) != 0) begin : g_odd_rounds
    $error("tea_decrypt_iter: ROUNDS must be even with TEA_DEC_UNROLL2_EN");
  end
`else
  localparam int unsigned STEPS    = ROUNDS;
  localparam logic [31:0] SUM_STEP = DELTA;
`endif

  if (ROUNDS < 1) begin : g_min_rounds
    $error("tea_decrypt_iter: ROUNDS must be at least 1");
  end

  localparam int unsigned    CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
  localparam logic [31:0]    SUM_INIT = TEA_SUM_INIT(ROUNDS, DELTA);

  state_t           state_q, state_d;
  logic [31:0]      v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  key_t             k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  block_t           dout_q, dout_d;
  logic [31:0]      r_v0, r_v1;

`ifdef TEA_DEC_UNROLL2_EN
  logic [31:0] m_v0, m_v1;

  // Second round sees the schedule one delta further down.
  tea_dec_round u_round0 (
    .v0_in (v0_q),
    .v1_in (v1_q),
    .sum_in(sum_q),
    .key_in(k_q),
    .v0_out(m_v0),
    .v1_out(m_v1)
  );

  tea_dec_round u_round1 (
    .v0_in (m_v0),
    .v1_in (m_v1),
    .sum_in(sum_q - DELTA),
    .key_in(k_q),
    .v0_out(r_v0),
    .v1_out(r_v1)
  );
`else
  tea_dec_round u_round0 (
    .v0_in (v0_q),
    .v1_in (v1_q),
    .sum_in(sum_q),
    .key_in(k_q),
    .v0_out(r_v0),
    .v1_out(r_v1)
  );
`endif

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          v0_d    = bus.data_in[63:32];
          v1_d    = bus.data_in[31:0];
          k_d     = bus.key;
          sum_d   = SUM_INIT;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        v0_d  = r_v0;
        v1_d  = r_v1;
        sum_d = sum_q - SUM_STEP;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          dout_d  = {r_v0, r_v1};
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = dout_q;

endmodule

// File: tb/tb_tea_decrypt_iter.sv
// Scoreboard bench for tea_decrypt_iter: known vector, busy-input isolation,
// random round trips via a TEA encipher model, backpressure and mid-run reset.
module tb_tea_decrypt_iter;

  localparam int unsigned ROUNDS = 32;
`ifdef TEA_DEC_UNROLL2_EN
  localparam int unsigned LAT = ROUNDS / 2;
`else
  localparam int unsigned LAT = ROUNDS;
`endif
  localparam logic [63:0] KNOWN_CT = 64'h41EA3A0A_94BAA940;

  logic clk = 1'b0;
  logic reset;

  tea_decrypt_iter_if bus ();

  tea_decrypt_iter #(.ROUNDS(ROUNDS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;
  int unsigned acc_cyc = 0;
  logic        ov_prev = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
    logic [31:0] v0, v1, s;
    v0 = p[63:32];
    v1 = p[31:0];
    s  = 32'h0;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      s  = s + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  // Accept-edge timestamp, taken from pre-edge handshake values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.in_valid && bus.in_ready) acc_cyc <= cyc + 1;
  end

  // Monitor: pops one expectation per new plaintext presentation.
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_valid_exclusive", {63'b0, bus.in_ready && bus.out_valid}, 64'd0);
      if (bus.out_valid && !ov_prev) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, required no output", bus.data_out);
        end else begin
          check("data_out", bus.data_out, exp_q.pop_front());
          check("latency", 64'(cyc - acc_cyc), 64'(LAT));
        end
      end
    end
    ov_prev <= bus.out_valid;
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: in_ready got 0, required 1 within 200 cycles");
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [127:0] k,
                      input logic [63:0] exp, input bit push);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.key      = k;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  logic [63:0]  pt, ct;
  logic [127:0] k;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.data_in   = '0;
    bus.key       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("reset_data_out", bus.data_out, 64'd0);

    // Known vector: key 0 deciphers to 0, in_ready low for the whole run.
    send(KNOWN_CT, '0, 64'h0, 1'b1);
    for (int i = 0; i < int'(LAT); i++) begin
      check("run_in_ready", {63'b0, bus.in_ready}, 64'd0);
      @(negedge clk);
    end
    check("known_out_valid", {63'b0, bus.out_valid}, 64'd1);
    drain();

    // Busy-input isolation: garbage offered every RUN cycle.
    send(KNOWN_CT, '0, 64'h0, 1'b1);
    for (int i = 0; i < int'(LAT); i++) begin
      bus.in_valid = 1'b1;
      bus.data_in  = {$urandom, $urandom};
      bus.key      = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();

    // Round trips through the encipher model.
    for (int n = 0; n < 100; n++) begin
      pt = {$urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      ct = tea_enc(pt, k);
      send(ct, k, pt, 1'b1);
    end
    drain();

    // Backpressure: result held while out_ready is low.
    bus.out_ready = 1'b0;
    pt = {$urandom, $urandom} | 64'h1;
    k  = {$urandom, $urandom, $urandom, $urandom};
    send(tea_enc(pt, k), k, pt, 1'b1);
    for (int i = 0; i < 200 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {63'b0, bus.out_valid}, 64'd1);
      check("bp_data_out", bus.data_out, pt);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("bp_release_in_ready", {63'b0, bus.in_ready}, 64'd1);
    drain();

    // Reset mid-run: no output from the aborted block, then a clean block.
    pt = {$urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    send(tea_enc(pt, k), k, pt, 1'b0);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("abort_data_out", bus.data_out, 64'd0);
    repeat (LAT + 4) @(negedge clk);
    pt = {$urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    send(tea_enc(pt, k), k, pt, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
